// File: rtl/countdown_pkg.sv
// Shared types and BCD limit constants for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [2:0] BCD_TENS_MAX = 3'd5;
  localparam logic [6:0] BCD_59       = 7'h59;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts clk cycles while enabled and flags one cycle per TICK_DIV.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // tick marks the cycle whose closing edge wraps the count
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss countdown timer with load/start/pause control.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int HR_MAX   = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] ld_hr,
  input  logic [6:0] ld_min,
  input  logic [6:0] ld_sec,
  input  logic       start,
  input  logic       pause,
  output logic [4:0] hr,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [4:0] HR_MAX_BIN = 5'(HR_MAX);
  localparam logic [4:0] HR_MAX_BCD = (HR_MAX >= 10) ? {1'b1, 4'(HR_MAX - 10)}
                                                     : {1'b0, 4'(HR_MAX)};

  function automatic logic [6:0] clamp_ms(input logic [6:0] v);
    if (v[6:4] > BCD_TENS_MAX || v[3:0] > BCD_ONES_MAX) return BCD_59;
    return v;
  endfunction

  function automatic logic [4:0] clamp_hr(input logic [4:0] v);
    logic [4:0] bin;
    bin = {1'b0, v[3:0]} + (v[4] ? 5'd10 : 5'd0);
    if (v[3:0] > BCD_ONES_MAX || bin > HR_MAX_BIN) return HR_MAX_BCD;
    return v;
  endfunction

  // 00 wraps to 59; the caller propagates the borrow upward
  function automatic logic [6:0] dec_ms(input logic [6:0] v);
    if (v[3:0] != 4'd0) return {v[6:4], v[3:0] - 4'd1};
    if (v[6:4] != 3'd0) return {v[6:4] - 3'd1, BCD_ONES_MAX};
    return BCD_59;
  endfunction

  function automatic logic [4:0] dec_hr(input logic [4:0] v);
    if (v[3:0] != 4'd0) return {v[4], v[3:0] - 4'd1};
    if (v[4]) return {1'b0, BCD_ONES_MAX};
    return 5'd0;
  endfunction

  state_t     state, state_n;
  logic [4:0] hr_q, hr_n, hr_d;
  logic [6:0] min_q, min_n, min_d;
  logic [6:0] sec_q, sec_n, sec_d;
  logic       done_q, done_n;
  logic       tick;
  logic       time_zero, dec_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [4:0] rl_hr;
  logic [6:0] rl_min, rl_sec;
  logic       rl_zero;
  assign rl_zero = (rl_hr == 5'd0) && (rl_min == 7'd0) && (rl_sec == 7'd0);
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_RUN),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    sec_d = dec_ms(sec_q);
    min_d = min_q;
    hr_d  = hr_q;
    if (sec_q == 7'd0) begin
      min_d = dec_ms(min_q);
      if (min_q == 7'd0) hr_d = dec_hr(hr_q);
    end
  end

  assign time_zero = (hr_q == 5'd0) && (min_q == 7'd0) && (sec_q == 7'd0);
  assign dec_zero  = (hr_d == 5'd0) && (min_d == 7'd0) && (sec_d == 7'd0);

  always_comb begin
    state_n = state;
    hr_n    = hr_q;
    min_n   = min_q;
    sec_n   = sec_q;
    done_n  = 1'b0;
    if (load) begin
      state_n = ST_IDLE;
      hr_n    = clamp_hr(ld_hr);
      min_n   = clamp_ms(ld_min);
      sec_n   = clamp_ms(ld_sec);
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (start && !time_zero) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            hr_n  = hr_d;
            min_n = min_d;
            sec_n = sec_d;
          end
          // expiry outranks a pause arriving on the same edge
          if (tick && dec_zero) begin
            done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (rl_zero) begin
              state_n = ST_DONE;
            end else begin
              hr_n  = rl_hr;
              min_n = rl_min;
              sec_n = rl_sec;
            end
`else
            state_n = ST_DONE;
`endif
          end else if (pause) begin
            state_n = ST_PAUSE;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      hr_q   <= hr_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      done_q <= done_n;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rl_hr  <= '0;
      rl_min <= '0;
      rl_sec <= '0;
    end else if (load) begin
      rl_hr  <= clamp_hr(ld_hr);
      rl_min <= clamp_ms(ld_min);
      rl_sec <= clamp_ms(ld_sec);
    end
  end
`endif

  assign hr      = hr_q;
  assign min     = min_q;
  assign sec     = sec_q;
  assign running = (state == ST_RUN);
  assign expired = (state == ST_DONE);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, HR_MAX=11.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [4:0] ld_hr = '0;
  logic [6:0] ld_min = '0;
  logic [6:0] ld_sec = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [4:0] hr;
  logic [6:0] min;
  logic [6:0] sec;
  logic       running, done, expired;

  int n_cmp = 0;
  int n_fail = 0;

  countdown_timer #(.TICK_DIV(4), .HR_MAX(11)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ld_hr   (ld_hr),
    .ld_min  (ld_min),
    .ld_sec  (ld_sec),
    .start   (start),
    .pause   (pause),
    .hr      (hr),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [6:0] m, input logic [6:0] s);
    load = 1'b1; ld_hr = h; ld_min = m; ld_sec = s;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if ({hr, min, sec} !== 19'd0) begin n_fail++; $display("FAIL reset_time: got %h:%h:%h want 00:00:00", hr, min, sec); end
    n_cmp++; if ({running, done, expired} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got r/d/e=%b%b%b want 000", running, done, expired); end
  endtask

  task automatic test_basic();
    logic [6:0] want_sec;
    do_load(5'h00, 7'h00, 7'h03);
    do_start();
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b want 1", running); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++; if (done !== (k == 12)) begin n_fail++; $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == 12)); end
      if (k == 3 || k == 4 || k == 8 || k == 12) begin
        case (k)
          3:       want_sec = 7'h03;
          4:       want_sec = 7'h02;
          8:       want_sec = 7'h01;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          default: want_sec = 7'h03;
`else
          default: want_sec = 7'h00;
`endif
        endcase
        n_cmp++; if (sec !== want_sec) begin n_fail++; $display("FAIL basic_sec k=%0d: got %h want %h", k, sec, want_sec); end
      end
    end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    n_cmp++; if ({running, expired} !== 2'b01) begin n_fail++; $display("FAIL basic_done_state: got run/exp=%b%b want 01", running, expired); end
    step();
    n_cmp++; if ({done, expired} !== 2'b01) begin n_fail++; $display("FAIL basic_done_hold: got done/exp=%b%b want 01", done, expired); end
    do_start();
    n_cmp++; if ({running, expired} !== 2'b01) begin n_fail++; $display("FAIL basic_start_in_done: got run/exp=%b%b want 01", running, expired); end
`endif
  endtask

  task automatic test_borrow();
    do_load(5'h01, 7'h00, 7'h00);
    do_start();
    for (int k = 1; k <= 3; k++) step();
    n_cmp++; if ({hr, min, sec} !== {5'h01, 7'h00, 7'h00}) begin n_fail++; $display("FAIL borrow_hr_early: got %h:%h:%h want 01:00:00", hr, min, sec); end
    step();
    n_cmp++; if ({hr, min, sec} !== {5'h00, 7'h59, 7'h59}) begin n_fail++; $display("FAIL borrow_hr: got %h:%h:%h want 00:59:59", hr, min, sec); end
    do_load(5'h00, 7'h10, 7'h00);
    do_start();
    for (int k = 1; k <= 4; k++) step();
    n_cmp++; if ({hr, min, sec} !== {5'h00, 7'h09, 7'h59}) begin n_fail++; $display("FAIL borrow_min: got %h:%h:%h want 00:09:59", hr, min, sec); end
  endtask

  task automatic test_pause();
    do_load(5'h00, 7'h00, 7'h05);
    do_start();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got running=%b want 0", running); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (sec !== 7'h05) begin n_fail++; $display("FAIL pause_frozen k=%0d: got %h want 05", k, sec); end
    end
    do_start();
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL pause_resume: got running=%b want 1", running); end
    step();
    n_cmp++; if (sec !== 7'h05) begin n_fail++; $display("FAIL pause_tick_early: got %h want 05", sec); end
    step();
    n_cmp++; if (sec !== 7'h04) begin n_fail++; $display("FAIL pause_tick: got %h want 04", sec); end
  endtask

  task automatic test_clamp_zero();
    do_load(5'h1F, 7'h7A, 7'h0A);
    n_cmp++; if ({hr, min, sec} !== {5'h11, 7'h59, 7'h59}) begin n_fail++; $display("FAIL clamp_digits: got %h:%h:%h want 11:59:59", hr, min, sec); end
    do_load(5'h12, 7'h45, 7'h30);
    n_cmp++; if ({hr, min, sec} !== {5'h11, 7'h45, 7'h30}) begin n_fail++; $display("FAIL clamp_hr_max: got %h:%h:%h want 11:45:30", hr, min, sec); end
    do_load(5'h10, 7'h00, 7'h60);
    n_cmp++; if ({hr, min, sec} !== {5'h10, 7'h00, 7'h59}) begin n_fail++; $display("FAIL clamp_sec_tens: got %h:%h:%h want 10:00:59", hr, min, sec); end
    do_load(5'h00, 7'h00, 7'h00);
    do_start();
    for (int k = 1; k <= 10; k++) begin
      n_cmp++; if ({running, done} !== 2'b00) begin n_fail++; $display("FAIL zero_start k=%0d: got run/done=%b%b want 00", k, running, done); end
      step();
    end
  endtask

  task automatic test_abort();
    do_load(5'h00, 7'h00, 7'h02);
    do_start();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({hr, min, sec, running, done, expired} !== 22'd0) begin n_fail++; $display("FAIL abort_rst: got %h:%h:%h r/d/e=%b%b%b want all 0", hr, min, sec, running, done, expired); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done k=%0d: got %b want 0", k, done); end
    end
    do_load(5'h00, 7'h00, 7'h03);
    do_start();
    step();
    load = 1'b1; start = 1'b1; ld_hr = 5'h00; ld_min = 7'h00; ld_sec = 7'h07;
    step();
    load = 1'b0; start = 1'b0;
    n_cmp++; if ({running, sec} !== {1'b0, 7'h07}) begin n_fail++; $display("FAIL load_start: got run=%b sec=%h want run=0 sec=07", running, sec); end
    for (int k = 1; k <= 5; k++) step();
    n_cmp++; if ({running, sec} !== {1'b0, 7'h07}) begin n_fail++; $display("FAIL load_idle_hold: got run=%b sec=%h want run=0 sec=07", running, sec); end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    do_load(5'h00, 7'h00, 7'h02);
    do_start();
    for (int k = 1; k <= 24; k++) begin
      step();
      n_cmp++; if (done !== ((k % 8) == 0)) begin n_fail++; $display("FAIL reload_done k=%0d: got %b want %b", k, done, ((k % 8) == 0)); end
      n_cmp++; if ({expired, running} !== 2'b01) begin n_fail++; $display("FAIL reload_state k=%0d: got exp/run=%b%b want 01", k, expired, running); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp_zero();
    test_abort();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have parameter HR_MAX, default 11, largest loadable hour value (range 1..19).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle request to load ld_hr/ld_min/ld_sec.
REQ-006 SHALL have port ld_hr  input  5  BCD hours: [4] tens, [3:0] ones.
REQ-007 SHALL have ports ld_min and ld_sec  input  7  each BCD: [6:4] tens, [3:0] ones.
REQ-008 SHALL have port start  input  1  one-cycle request to begin or resume counting.
REQ-009 SHALL have port pause  input  1  one-cycle request to suspend counting.
REQ-010 SHALL have ports hr 5 / min 7 / sec 7  output  current remaining time, same BCD layout as the load ports.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on expiry.
REQ-013 SHALL have port expired  output  1  level, high while in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL give per-cycle priority load > pause > start.
REQ-016 SHALL on load, from any state, register the clamped time and enter IDLE.
REQ-017 SHALL clamp on load: any seconds/minutes digit out of range -> 59; BCD ones >9 or hour >HR_MAX -> HR_MAX.
REQ-018 SHALL on start in IDLE or PAUSE enter RUN only if time != 00:00:00; otherwise ignore it.
REQ-019 SHALL on pause in RUN enter PAUSE and hold the prescaler count.
REQ-020 SHALL ignore start in RUN/DONE and pause outside RUN.
REQ-021 SHALL advance the prescaler only in RUN and clear it on load and rst.
REQ-022 SHALL raise an internal tick for one cycle each time the prescaler wraps at TICK_DIV-1.
REQ-023 SHALL subtract one second per tick in BCD.
REQ-024 SHALL apply BCD borrows: sec ones 0->9 borrows tens; sec 00->59 borrows one minute; min 00->59 borrows one hour.
REQ-025 SHALL make the tick that yields 00:00:00 move the state to DONE on the same edge.
REQ-026 SHALL assert done in the first DONE cycle only, keep expired high throughout DONE, and leave DONE only on load or rst.
REQ-027 SHALL drive hr/min/sec directly from registers, so values change on the edge after tick with zero combinational path from inputs.

Reset
REQ-028 SHALL on rst force state IDLE, time 00:00:00, prescaler 0, and running=done=expired=0.
REQ-029 SHALL give rst priority over load/start/pause, including mid-RUN, where it aborts the count with no done pulse.

Configuration
REQ-030 SHALL with COUNTDOWN_AUTO_RELOAD_EN defined, on expiry, pulse done for one cycle, reload the last loaded value, and stay in RUN with expired held 0 and DONE unused; a last-loaded value of 0 goes to DONE as normal.
REQ-031 SHALL without COUNTDOWN_AUTO_RELOAD_EN, hold in DONE per REQ-026 and omit the reload registers.

Structure
REQ-032 SHALL place the state enum and BCD limit constants (9, 5, 59) in shared package countdown_pkg.
REQ-033 SHALL put the prescaler in sub-module tick_gen (ports clk, rst, en, clr, tick; parameter TICK_DIV).

Verification
REQ-034 SHALL verify with TICK_DIV=4: load 00:00:03, start -> done pulses exactly 12 cycles after start; sec sequence 02,01,00.
REQ-035 SHALL verify the borrow chain: load 01:00:00, start, one tick -> 00:59:59; load 00:10:00, one tick -> 00:09:59.
REQ-036 SHALL verify pause: run 2 cycles, pause 10 cycles, start -> next tick exactly 2 cycles after resume, with time frozen during PAUSE.
REQ-037 SHALL verify clamp and zero-start: load hr=5'h1F, min=7'h7A -> hr=HR_MAX, min=59; load 00:00:00 then start -> running stays 0 and done never pulses.
REQ-038 SHALL verify mid-run aborts: rst mid-RUN -> all outputs 0 next cycle, no done; load and start in the same cycle -> IDLE with new value.
REQ-039 SHALL verify auto-reload with COUNTDOWN_AUTO_RELOAD_EN: load 00:00:02, start -> done pulses every 8 cycles, expired never high.
